// File: rtl/dmem_arbiter.sv
// dmem_arbiter: lets the CPU execute stage and a host/debug port share one
// data-memory port.
// - The CPU has priority and sees zero-latency access.
// - The host gets a registered one-cycle slot (HACC), followed by a
//   completion cycle (HRSP) in which host_done pulses.
// Optional feature: define DMEM_ARB_STARVE_EN to add a starvation counter.
// With it, a host that has been blocked for STARVE_MAX cycles is forced in.
// The CPU then loses one cycle to a stall.
module dmem_arbiter #(
    parameter int AW         = 8,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rstd,
    input  logic          cpu_req,
    input  logic [AW-1:0] cpu_addr,
    input  logic [31:0]   cpu_wdata,
    input  logic [3:0]    cpu_wren_n,
    output logic [31:0]   cpu_rdata,
    output logic          cpu_stall,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [31:0]   host_wdata,
    output logic          host_gnt,
    output logic          host_done,
    output logic [31:0]   host_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_wren_n,
    input  logic [31:0]   mem_rdata
);

    // The unused code 2'b11 is treated exactly like IDLE.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HACC = 2'd1,
        S_HRSP = 2'd2
    } state_t;

    state_t        r_state;
    logic          r_host_gnt;
    logic          r_host_done;
    logic [31:0]   r_host_rdata;
    logic          w_host_own;
    logic          w_grant;

    assign w_host_own = (r_state == S_HACC);

`ifdef DMEM_ARB_STARVE_EN
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0] r_starve_cnt;
    logic       w_in_idle;

    assign w_in_idle = (r_state != S_HACC) && (r_state != S_HRSP);

    // Count consecutive cycles in which the host is blocked by the CPU.
    // The count saturates at the limit and clears once the host is served
    // or withdraws its request.
    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            r_starve_cnt <= 4'd0;
        end else if (w_host_own || !host_req) begin
            r_starve_cnt <= 4'd0;
        end else if (w_in_idle && cpu_req && (r_starve_cnt != STARVE_LIM)) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
        end
    end

    assign w_grant = host_req && (!cpu_req || (r_starve_cnt == STARVE_LIM));
`else
    // Strict CPU priority: the host only gets in on cycles the CPU is idle.
    assign w_grant = host_req && !cpu_req;
`endif

    // Ownership FSM with registered grant/done flags and the host read capture.
    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            r_state      <= S_IDLE;
            r_host_gnt   <= 1'b0;
            r_host_done  <= 1'b0;
            r_host_rdata <= 32'd0;
        end else begin
            case (r_state)
                S_HACC: begin
                    r_state     <= S_HRSP;
                    r_host_gnt  <= 1'b0;
                    r_host_done <= 1'b1;
                    if (!host_we) begin
                        r_host_rdata <= mem_rdata;
                    end
                end
                S_HRSP: begin
                    // host_req is deliberately not sampled here.
                    r_state     <= S_IDLE;
                    r_host_gnt  <= 1'b0;
                    r_host_done <= 1'b0;
                end
                default: begin
                    r_state     <= w_grant ? S_HACC : S_IDLE;
                    r_host_gnt  <= w_grant;
                    r_host_done <= 1'b0;
                end
            endcase
        end
    end

    // Memory port mux.
    // A stalled CPU never drives the port, so its write enables are dropped.
    always_comb begin
        mem_addr   = cpu_addr;
        mem_wdata  = cpu_wdata;
        mem_wren_n = cpu_req ? cpu_wren_n : 4'b1111;
        if (w_host_own) begin
            mem_addr   = host_addr;
            mem_wdata  = host_wdata;
            mem_wren_n = host_we ? 4'b0000 : 4'b1111;
        end
    end

    assign cpu_rdata  = mem_rdata;
    assign cpu_stall  = cpu_req && w_host_own;
    assign host_gnt   = r_host_gnt;
    assign host_done  = r_host_done;
    assign host_rdata = r_host_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter.
// - Uses a behavioural 256x32 lane-writable memory.
// - Runs a table of directed per-cycle vectors.
// - Follows with hand-written sequences for starvation and mid-access reset.
// Expectations for starvation depend on DMEM_ARB_STARVE_EN.
module tb_dmem_arbiter;

    localparam int AW = 8;
    localparam int SMAX = 4;

    logic          clk = 1'b0;
    logic          rstd;
    logic          cpu_req;
    logic [AW-1:0] cpu_addr;
    logic [31:0]   cpu_wdata;
    logic [3:0]    cpu_wren_n;
    logic [31:0]   cpu_rdata;
    logic          cpu_stall;
    logic          host_req;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [31:0]   host_wdata;
    logic          host_gnt;
    logic          host_done;
    logic [31:0]   host_rdata;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_wren_n;
    logic [31:0]   mem_rdata;

    int n_total = 0;
    int n_bad   = 0;

    logic [31:0] mem [0:255];

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(AW), .STARVE_MAX(SMAX)) dut (
        .clk        (clk),
        .rstd       (rstd),
        .cpu_req    (cpu_req),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_wren_n (cpu_wren_n),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .host_req   (host_req),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_gnt   (host_gnt),
        .host_done  (host_done),
        .host_rdata (host_rdata),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wren_n (mem_wren_n),
        .mem_rdata  (mem_rdata)
    );

    // Memory banks: combinational read, per-lane active-low write
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        for (int l = 0; l < 4; l++) begin
            if (!mem_wren_n[l]) mem[mem_addr][8*l +: 8] <= mem_wdata[8*l +: 8];
        end
    end

    typedef struct {
        logic        cr;  logic [7:0] ca; logic [31:0] cd; logic [3:0] cw;
        logic        hr;  logic hw;       logic [7:0] ha;  logic [31:0] hd;
        logic [3:0]  ew;  logic [7:0] ea;
        logic        eg;  logic ed;       logic es;
        logic        cc;  logic [31:0] ecr;
        logic        hc;  logic [31:0] ehr;
    } vec_t;

    function automatic vec_t mk(
        input logic cr, input logic [7:0] ca, input logic [31:0] cd, input logic [3:0] cw,
        input logic hr, input logic hw, input logic [7:0] ha, input logic [31:0] hd,
        input logic [3:0] ew, input logic [7:0] ea,
        input logic eg, input logic ed, input logic es,
        input logic cc, input logic [31:0] ecr,
        input logic hc, input logic [31:0] ehr);
        vec_t v;
        v.cr = cr; v.ca = ca; v.cd = cd; v.cw = cw;
        v.hr = hr; v.hw = hw; v.ha = ha; v.hd = hd;
        v.ew = ew; v.ea = ea; v.eg = eg; v.ed = ed; v.es = es;
        v.cc = cc; v.ecr = ecr; v.hc = hc; v.ehr = ehr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        cpu_req = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_wren_n = 4'hF;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    endtask

    vec_t vt [$];

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int first_gnt;
        int stall_n;
        bit done_seen;

        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        mem[8'h11] = 32'h55667788;
        rstd = 1'b0;
        drive_idle();

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt",   {31'd0, host_gnt},  32'd0);
        chk("rst_done",  {31'd0, host_done}, 32'd0);
        chk("rst_stall", {31'd0, cpu_stall}, 32'd0);
        chk("rst_hrd",   host_rdata,         32'd0);
        chk("rst_wren",  {28'd0, mem_wren_n}, 32'hF);
        rstd = 1'b1;

        // ---------------- vector table ----------------
        //         cr ca     cd            cw    hr hw ha     hd            ew    ea     eg ed es cc ecr           hc ehr
        vt.push_back(mk(0, 8'h00, 32'h0,        4'hF, 0, 0, 8'h00, 32'h0,        4'hF, 8'h00, 0, 0, 0, 0, 32'h0,        1, 32'h0));
        vt.push_back(mk(1, 8'h10, 32'hDEADBEEF, 4'h0, 0, 0, 8'h00, 32'h0,        4'h0, 8'h10, 0, 0, 0, 0, 32'h0,        0, 32'h0));
        vt.push_back(mk(1, 8'h10, 32'h0,        4'hF, 0, 0, 8'h00, 32'h0,        4'hF, 8'h10, 0, 0, 0, 1, 32'hDEADBEEF, 0, 32'h0));
        vt.push_back(mk(1, 8'h11, 32'h0000ABCD, 4'hC, 0, 0, 8'h00, 32'h0,        4'hC, 8'h11, 0, 0, 0, 1, 32'h55667788, 0, 32'h0));
        vt.push_back(mk(1, 8'h11, 32'h0,        4'hF, 0, 0, 8'h00, 32'h0,        4'hF, 8'h11, 0, 0, 0, 1, 32'h5566ABCD, 0, 32'h0));
        vt.push_back(mk(0, 8'h12, 32'hFFFFFFFF, 4'h0, 0, 0, 8'h00, 32'h0,        4'hF, 8'h12, 0, 0, 0, 0, 32'h0,        0, 32'h0));
        vt.push_back(mk(0, 8'h12, 32'h0,        4'hF, 1, 1, 8'h20, 32'h12345678, 4'hF, 8'h12, 0, 0, 0, 1, 32'h0,        0, 32'h0));
        vt.push_back(mk(0, 8'h12, 32'h0,        4'hF, 1, 1, 8'h20, 32'h12345678, 4'h0, 8'h20, 1, 0, 0, 0, 32'h0,        0, 32'h0));
        vt.push_back(mk(0, 8'h12, 32'h0,        4'hF, 1, 1, 8'h20, 32'h12345678, 4'hF, 8'h12, 0, 1, 0, 0, 32'h0,        0, 32'h0));
        vt.push_back(mk(1, 8'h20, 32'h0,        4'hF, 0, 0, 8'h00, 32'h0,        4'hF, 8'h20, 0, 0, 0, 1, 32'h12345678, 0, 32'h0));
        vt.push_back(mk(0, 8'h00, 32'h0,        4'hF, 1, 0, 8'h11, 32'h0,        4'hF, 8'h00, 0, 0, 0, 0, 32'h0,        0, 32'h0));
        vt.push_back(mk(0, 8'h00, 32'h0,        4'hF, 1, 0, 8'h11, 32'h0,        4'hF, 8'h11, 1, 0, 0, 1, 32'h5566ABCD, 0, 32'h0));
        vt.push_back(mk(0, 8'h00, 32'h0,        4'hF, 1, 0, 8'h11, 32'h0,        4'hF, 8'h00, 0, 1, 0, 0, 32'h0,        1, 32'h5566ABCD));
        vt.push_back(mk(0, 8'h00, 32'h0,        4'hF, 0, 0, 8'h00, 32'h0,        4'hF, 8'h00, 0, 0, 0, 0, 32'h0,        1, 32'h5566ABCD));
        vt.push_back(mk(0, 8'h00, 32'h0,        4'hF, 1, 1, 8'h30, 32'hCAFEF00D, 4'hF, 8'h00, 0, 0, 0, 0, 32'h0,        0, 32'h0));
        vt.push_back(mk(1, 8'h31, 32'h11111111, 4'h0, 1, 1, 8'h30, 32'hCAFEF00D, 4'h0, 8'h30, 1, 0, 1, 0, 32'h0,        0, 32'h0));
        vt.push_back(mk(1, 8'h31, 32'h11111111, 4'h0, 1, 1, 8'h30, 32'hCAFEF00D, 4'h0, 8'h31, 0, 1, 0, 1, 32'h0,        0, 32'h0));
        vt.push_back(mk(1, 8'h31, 32'h0,        4'hF, 0, 0, 8'h00, 32'h0,        4'hF, 8'h31, 0, 0, 0, 1, 32'h11111111, 0, 32'h0));
        vt.push_back(mk(1, 8'h30, 32'h0,        4'hF, 0, 0, 8'h00, 32'h0,        4'hF, 8'h30, 0, 0, 0, 1, 32'hCAFEF00D, 0, 32'h0));
        vt.push_back(mk(1, 8'h10, 32'h0,        4'hF, 0, 0, 8'h00, 32'h0,        4'hF, 8'h10, 0, 0, 0, 1, 32'hDEADBEEF, 0, 32'h0));
        vt.push_back(mk(0, 8'h10, 32'h0,        4'hF, 1, 0, 8'h20, 32'h0,        4'hF, 8'h10, 0, 0, 0, 0, 32'h0,        0, 32'h0));
        vt.push_back(mk(0, 8'h10, 32'h0,        4'hF, 1, 0, 8'h20, 32'h0,        4'hF, 8'h20, 1, 0, 0, 1, 32'h12345678, 0, 32'h0));
        vt.push_back(mk(0, 8'h10, 32'h0,        4'hF, 1, 0, 8'h20, 32'h0,        4'hF, 8'h10, 0, 1, 0, 0, 32'h0,        1, 32'h12345678));
        vt.push_back(mk(0, 8'h10, 32'h0,        4'hF, 0, 0, 8'h00, 32'h0,        4'hF, 8'h10, 0, 0, 0, 0, 32'h0,        1, 32'h12345678));

        for (int i = 0; i < vt.size(); i++) begin
            @(posedge clk); #1;
            cpu_req = vt[i].cr; cpu_addr = vt[i].ca; cpu_wdata = vt[i].cd; cpu_wren_n = vt[i].cw;
            host_req = vt[i].hr; host_we = vt[i].hw; host_addr = vt[i].ha; host_wdata = vt[i].hd;
            @(negedge clk);
            chk($sformatf("v%0d_wren", i),  {28'd0, mem_wren_n}, {28'd0, vt[i].ew});
            chk($sformatf("v%0d_addr", i),  {24'd0, mem_addr},   {24'd0, vt[i].ea});
            chk($sformatf("v%0d_gnt", i),   {31'd0, host_gnt},   {31'd0, vt[i].eg});
            chk($sformatf("v%0d_done", i),  {31'd0, host_done},  {31'd0, vt[i].ed});
            chk($sformatf("v%0d_stall", i), {31'd0, cpu_stall},  {31'd0, vt[i].es});
            if (vt[i].cc) chk($sformatf("v%0d_crd", i), cpu_rdata,  vt[i].ecr);
            if (vt[i].hc) chk($sformatf("v%0d_hrd", i), host_rdata, vt[i].ehr);
            $display("vec %0d: wren_n=%b addr=%h gnt=%b done=%b stall=%b crd=%h hrd=%h",
                     i, mem_wren_n, mem_addr, host_gnt, host_done, cpu_stall, cpu_rdata, host_rdata);
        end

        // ---------------- starvation: CPU hogs the port, host reads 0x20 ----------------
        @(posedge clk); #1;
        drive_idle();
        cpu_req = 1'b1; cpu_addr = 8'h10;
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'h20;
        first_gnt = -1; stall_n = 0; done_seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (host_gnt && first_gnt < 0) first_gnt = i;
            if (cpu_stall) stall_n++;
            if (host_done) begin
                done_seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
`ifdef DMEM_ARB_STARVE_EN
        chk("starve_gnt_cycle", first_gnt, SMAX + 1);
        chk("starve_stall_cnt", stall_n, 1);
        chk("starve_done",      {31'd0, done_seen}, 32'd1);
        chk("starve_hrd",       host_rdata, 32'h12345678);
        $display("starve: forced grant in cycle %0d, stall cycles %0d", first_gnt, stall_n);
        @(posedge clk); #1;
        host_req = 1'b0;
`else
        chk("nostarve_no_gnt",   first_gnt, -1);
        chk("nostarve_no_stall", stall_n, 0);
        cpu_req = 1'b0;
        @(negedge clk);
        chk("nostarve_gnt_edge", {31'd0, host_gnt}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("nostarve_gnt",      {31'd0, host_gnt}, 32'd1);
        chk("nostarve_stall",    {31'd0, cpu_stall}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("nostarve_done",     {31'd0, host_done}, 32'd1);
        chk("nostarve_hrd",      host_rdata, 32'h12345678);
        $display("nostarve: host served after cpu_req dropped, hrd=%h", host_rdata);
        @(posedge clk); #1;
        host_req = 1'b0;
`endif

        // ---------------- reset in the middle of HACC ----------------
        @(posedge clk); #1;
        drive_idle();
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'h10;
        @(posedge clk); #1;
        chk("mid_gnt_before", {31'd0, host_gnt}, 32'd1);
        cpu_req = 1'b1; cpu_addr = 8'h40;
        #1 rstd = 1'b0;
        #1;
        chk("mid_gnt",   {31'd0, host_gnt},  32'd0);
        chk("mid_done",  {31'd0, host_done}, 32'd0);
        chk("mid_hrd",   host_rdata,         32'd0);
        chk("mid_stall", {31'd0, cpu_stall}, 32'd0);
        cpu_req = 1'b0; host_req = 1'b0;
        #1;
        chk("mid_wren",  {28'd0, mem_wren_n}, 32'hF);
        @(negedge clk);
        rstd = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("post_rst_done%0d", i), {31'd0, host_done}, 32'd0);
            chk($sformatf("post_rst_gnt%0d", i),  {31'd0, host_gnt},  32'd0);
        end
        $display("reset mid-HACC: gnt=%b done=%b hrd=%h", host_gnt, host_done, host_rdata);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbiter that shares the single data-memory port (four byte-lane banks, 8-bit word address, combinational read, active-low per-lane write enable) between the CPU execute stage and a host/debug access port used to preload or inspect data memory. The CPU has priority and sees zero-latency access when it owns the port. The host is served in a registered one-cycle slot, during which a requesting CPU is stalled (PC hold, register write inhibited).

## Interface
Parameters:
- AW, 8, word-address width
- STARVE_MAX, 4, consecutive blocked host cycles before the host is forced in; range 1..15

Ports:
- clk  in  1  clock, all state on posedge
- rstd  in  1  reset, asynchronous, active-low
- cpu_req  in  1  CPU load/store this cycle
- cpu_addr  in  AW  CPU word address
- cpu_wdata  in  32  CPU store data
- cpu_wren_n  in  4  CPU lane write enables, active-low (1111 = load)
- cpu_rdata  out  32  equals mem_rdata
- cpu_stall  out  1  CPU must hold PC and suppress register write
- host_req  in  1  host request; fields held stable until host_done
- host_we  in  1  1 = full-word write, 0 = read
- host_addr  in  AW  host word address
- host_wdata  in  32  host write data
- host_gnt  out  1  host owns the memory port this cycle
- host_done  out  1  one-cycle completion pulse
- host_rdata  out  32  registered host read data
- mem_addr  out  AW  to memory banks
- mem_wdata  out  32  to memory banks, lane i = bits 8i+7:8i
- mem_wren_n  out  4  to memory banks, active-low
- mem_rdata  in  32  from memory banks

## Operation
- State register: IDLE, HACC, HRSP; 2-bit encoding, remaining code decodes to IDLE.
- IDLE: port owned by CPU. Move to HACC at the edge when host_req && (!cpu_req || starve_cnt == STARVE_MAX).
- HACC: port owned by host; host_gnt=1. Read: host_rdata <= mem_rdata at the closing edge. Write: mem_wren_n=0000, mem_wdata=host_wdata. Always move to HRSP.
- HRSP: port owned by CPU; host_done=1; host_req is not sampled. Always move to IDLE.
- Port mux: host owner drives host_addr/host_wdata/(host_we?0000:1111). CPU owner drives cpu_addr/cpu_wdata/(cpu_req?cpu_wren_n:1111).
- cpu_stall = cpu_req && state==HACC (combinational). While the CPU is stalled its write enables never reach memory.
- starve_cnt (4 bits): in IDLE, increments (saturating at STARVE_MAX) when host_req && cpu_req; cleared in HACC or when host_req=0.
- Host writes are always full-word. Partial-lane writes are CPU-only.

## Timing
- Reset values: state IDLE, starve_cnt 0, host_rdata 0, host_done 0, host_gnt 0, cpu_stall 0, mem_wren_n 1111 while cpu_req=0.
- CPU access: 0-cycle latency, same cycle as cpu_req. Store commits at the next posedge.
- Host access: request seen at edge N, HACC in cycle N+1, host_done in cycle N+2. Minimum spacing between grants is 3 cycles.
- host_req rising in the same cycle cpu_req falls: grant at that edge, HACC next cycle.
- cpu_req rising while in HACC: stalled exactly that cycle, served in HRSP.
- Host request arriving during HRSP: ignored until IDLE.
- Reset mid-operation (any state): immediately IDLE. No host_done, host_rdata cleared. Host must re-request.

## Configuration
- DMEM_ARB_STARVE_EN defined: starvation counter is present. The host is forced in after STARVE_MAX blocked cycles, costing the CPU one stall cycle.
- Not defined: starve_cnt is removed and the grant condition is host_req && !cpu_req only (strict CPU priority). The host can wait indefinitely.

## Test plan
- Reset: assert rstd=0 mid-HACC -> state IDLE, host_done 0, host_rdata 0, host_gnt 0, cpu_stall 0; with cpu_req=0, mem_wren_n=1111.
- CPU store addr 0x10, data 0xDEADBEEF, wren_n 0000, no host -> mem_wren_n 0000 same cycle, cpu_stall 0. Next cycle CPU load 0x10 gives cpu_rdata 0xDEADBEEF.
- CPU halfword store addr 0x11, wren_n 1100, data 0x0000ABCD -> only lanes 0-1 written. A host read of 0x11 returns 0x????ABCD with upper lanes unchanged.
- Host write addr 0x20, data 0x12345678, cpu_req=0 -> host_gnt in the next cycle with mem_wren_n 0000, host_done one cycle later. CPU load 0x20 reads 0x12345678.
- Starvation: cpu_req held high, host read of 0x20, STARVE_MAX=4. With the macro: grant after 4 blocked cycles, cpu_stall high exactly 1 cycle, host_rdata 0x12345678. Without the macro: no grant until cpu_req drops, then grant at the next edge.
- cpu_req rises during HACC -> cpu_stall=1 in that cycle only, and the CPU store does not reach memory until HRSP.
